regfile_wr_arbiter: RTL
=======================

# regfile_wr_arbiter

Write-port arbiter and initialiser for the 32×16 `registerfile`. It shares the register file's single write port (`Rw`, `WrEn`, `busW`) among `NUM_REQ` producers, for example the ALU result, load return and immediate move, using round-robin valid/ready arbitration. It also runs a sweep sequencer that writes `INIT_VAL` to every register after reset or on request. It sits between the execution units and `registerfile`; the read ports are not touched.

## Interface
- `NUM_REQ`, 3: number of write requesters (2..8).
- `ADDR_W`, 5: register address width; the sweep covers 2^ADDR_W registers.
- `DATA_W`, 16: register data width.
- `INIT_VAL`, 0: value written to every register during a sweep.
- `INIT_ON_RESET`, 1: 1 means a sweep starts automatically when `rst` deasserts.

Ports:
- `clk` in, 1: sole clock, rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `init_req` in, 1: single-cycle pulse that starts a sweep.
- `init_busy` out, 1: high while a sweep is in progress.
- `req_valid` in, NUM_REQ: per-requester write request.
- `req_ready` out, NUM_REQ: per-requester grant (combinational).
- `req_addr` in, NUM_REQ*ADDR_W: packed addresses; requester i occupies `[i*ADDR_W +: ADDR_W]`.
- `req_data` in, NUM_REQ*DATA_W: packed write data, laid out the same way.
- `Rw` out, ADDR_W: write address to `registerfile`.
- `WrEn` out, 1: write enable to `registerfile`.
- `busW` out, DATA_W: write data to `registerfile`.
- `grant_id` out, clog2(NUM_REQ): index of the requester whose write is on `Rw`/`busW` this cycle; 0 during a sweep.

## Operation
- States: `RESET`, `INIT`, `ARB`.
- During `rst`:
  - `WrEn=0`, `Rw=0`, `busW=0`, `grant_id=0`, `req_ready=0`, `init_busy=0`.
  - Round-robin pointer = 0, sweep counter = 0.
- On leaving `rst`:
  - Next state is `INIT` if `INIT_ON_RESET=1`, otherwise `ARB`.
- `INIT`:
  - `init_busy=1` and `req_ready=0` throughout.
  - Each cycle the output register loads `WrEn=1`, `Rw=counter`, `busW=INIT_VAL`, then the counter increments.
  - After the write to address 2^ADDR_W−1, the state moves to `ARB` and the counter returns to 0.
  - `init_req` is ignored; the sweep does not restart.
- `ARB`:
  - The search starts at the pointer and takes the first requester i (modulo NUM_REQ) with `req_valid[i]=1`.
  - `req_ready[i]=1` for that requester only.
  - The handshake (`valid && ready`) loads `Rw=req_addr[i]`, `busW=req_data[i]`, `WrEn=1`, `grant_id=i` into the output register, and the pointer becomes (i+1) mod NUM_REQ.
  - With no valid requester, `WrEn=0`; `Rw`/`busW` hold their last values and the pointer is unchanged.
- `init_req` while in `ARB`:
  - All `req_ready` are forced to 0 in that cycle and no grant occurs.
  - The state moves to `INIT`.
- Address 0 receives no special treatment; any protection of register 0 belongs to `registerfile`.
- A requester must hold `req_valid`, `req_addr` and `req_data` stable until it sees `req_ready`. The arbiter never drops a presented request.

## Timing
- Write latency: a handshake in cycle N puts `WrEn=1` on the port in cycle N+1, and the register file commits at the N+2 edge. All write-port outputs are registered.
- Throughput: one write per cycle. With every requester continuously valid, each one is granted every NUM_REQ cycles.
- Sweep length: exactly 2^ADDR_W cycles of `WrEn=1` (32 by default). `init_busy` rises in the cycle after `rst` falls (or after `init_req` is sampled) and falls in the cycle after the last sweep write.
- `rst` asserted mid-sweep or mid-grant: the outputs clear at the next edge. An in-flight registered write is dropped, not completed, and the sweep restarts from address 0.
- `init_req` and `rst` high together: `rst` wins.
- No combinational path from `req_valid` to `WrEn`/`Rw`/`busW`. `req_ready` depends combinationally on `req_valid`, the pointer and the state.

## Structure
- Shared package `regfile_pkg`:
  - `ADDR_W` and `DATA_W` defaults, and the register count of 2^ADDR_W.
  - The state encoding `RESET`/`INIT`/`ARB`.
- Sub-module `rr_arbiter` (generic NUM_REQ round-robin: request vector and pointer in, one-hot grant and index out). It is reused by later read-port sharing.
- The sweep counter and output register stay in the top module.

## Test plan
- Reset sweep: release `rst` with `INIT_ON_RESET=1`.
  - Expect 32 consecutive cycles of `WrEn=1` with `Rw` = 0..31 and `busW`=0x0000, then `init_busy=0`.
  - Reading `registerfile` then returns 0 at every address.
- Single request: requester 1 presents `addr`=5'h01, `data`=16'h0001.
  - `req_ready[1]` is high the same cycle.
  - The next cycle shows `WrEn=1`, `Rw`=1, `busW`=16'h0001, `grant_id`=1.
  - `busA` reads 16'h0001 with `Ra`=1.
- Fairness: all three requesters are valid continuously, with data 16'hA000+i.
  - Grant order is 0, 1, 2, 0, 1, 2 with one write per cycle, and no requester waits more than 2 cycles.
- Collision: requesters 0 and 2 both target `addr`=5'h1F with data 16'hFFFF and 16'h1234.
  - Both are serialised in round-robin order, and the register holds the later-granted value.
- `init_req` while requester 0 is valid:
  - No grant occurs that cycle, and `req_ready` stays 0 for the full 32-cycle sweep.
  - The held request is written in the first cycle after the sweep ends.
- `rst` pulse at sweep address 10: the outputs are cleared the next cycle, and the sweep restarts at `Rw`=0 after `rst` falls.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port logic: default widths,
// register count and the write-arbiter state encoding.
package regfile_pkg;

  localparam int REGFILE_ADDR_W   = 5;
  localparam int REGFILE_DATA_W   = 16;
  localparam int REGFILE_NUM_REGS = 1 << REGFILE_ADDR_W;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    INIT  = 2'd1,
    ARB   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: the search starts at i_ptr and wraps modulo
// NUM_REQ; the first asserted request wins and is reported one-hot and as an index.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int w_pos;

  // Walk offsets from farthest to nearest so the requester closest to the
  // pointer overwrites any earlier hit.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (i_req[w_pos]) begin
        o_grant        = '0;
        o_grant[w_pos] = 1'b1;
        o_idx          = IDX_W'(w_pos);
        o_valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port among NUM_REQ producers (round-robin)
// and sweeps INIT_VAL into every register after reset or on init_req.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int                NUM_REQ       = 3,
  parameter int                ADDR_W        = REGFILE_ADDR_W,
  parameter int                DATA_W        = REGFILE_DATA_W,
  parameter logic [DATA_W-1:0] INIT_VAL      = '0,
  parameter bit                INIT_ON_RESET = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         init_req,
  output logic                         init_busy,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [ADDR_W-1:0]            Rw,
  output logic                         WrEn,
  output logic [DATA_W-1:0]            busW,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output state_t                       o_dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [IDX_W-1:0]    r_ptr;
  logic                r_wren;
  logic [ADDR_W-1:0]   r_rw;
  logic [DATA_W-1:0]   r_busw;
  logic [IDX_W-1:0]    r_gid;

  logic                w_arb_en;
  logic [NUM_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]    w_idx;
  logic                w_fire;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;

  // Handshake: a requester's write is accepted in the cycle where its
  // req_valid and req_ready are both high; it must hold valid/addr/data
  // stable until then. Ready is offered only in ARB, never under rst, and
  // never in the cycle init_req is seen, so a held request waits out a sweep.
  assign w_arb_en = (r_state == ARB) && !rst && !init_req;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .i_req   (req_valid & {NUM_REQ{w_arb_en}}),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_fire)
  );

  assign req_ready  = w_grant;
  assign w_sel_addr = req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
  assign w_sel_data = req_data[int'(w_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RESET;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_wren  <= 1'b0;
      r_rw    <= '0;
      r_busw  <= '0;
      r_gid   <= '0;
    end else begin
      case (r_state)
        RESET: begin
          r_wren  <= 1'b0;
          r_cnt   <= '0;
          r_state <= INIT_ON_RESET ? INIT : ARB;
        end
        INIT: begin
          r_wren <= 1'b1;
          r_rw   <= r_cnt;
          r_busw <= INIT_VAL;
          r_gid  <= '0;
          if (&r_cnt) begin
            r_cnt   <= '0;
            r_state <= ARB;
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
        ARB: begin
          if (init_req) begin
            r_wren  <= 1'b0;
            r_cnt   <= '0;
            r_state <= INIT;
          end else if (w_fire) begin
            r_wren <= 1'b1;
            r_rw   <= w_sel_addr;
            r_busw <= w_sel_data;
            r_gid  <= w_idx;
            r_ptr  <= (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
          end else begin
            r_wren <= 1'b0;
          end
        end
        default: begin
          r_wren  <= 1'b0;
          r_state <= RESET;
        end
      endcase
    end
  end

  assign WrEn        = r_wren;
  assign Rw          = r_rw;
  assign busW        = r_busw;
  assign grant_id    = r_gid;
  assign init_busy   = (r_state == INIT);
  assign o_dbg_state = r_state;

endmodule
